// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: steps pre-round plus NR rounds through a single-round datapath.
// Optional decryption key ordering is built when AES_DECRYPT_EN is defined.
module aes_round_ctrl #(
  parameter int unsigned NR     = 10,
  parameter int unsigned RIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              rk_valid,
  output logic [RIDX_W-1:0] key_idx,
  output logic              mux_sel,
  output logic              state_we,
  output logic [RIDX_W-1:0] round_idx,
  output logic              last_round,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready
`ifdef AES_DECRYPT_EN
  ,
  input  logic              dec
`endif
);

  localparam logic [RIDX_W-1:0] NR_IDX  = RIDX_W'(NR);
  localparam logic [RIDX_W-1:0] ONE_IDX = RIDX_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

`ifdef AES_DECRYPT_EN
  logic dec_q;
`endif

  // Sequencer: round counter advances only on a consumed round key.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      round_idx  <= '0;
      mux_sel    <= 1'b0;
      last_round <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
`ifdef AES_DECRYPT_EN
      dec_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= LOAD;
            round_idx <= '0;
            busy      <= 1'b1;
`ifdef AES_DECRYPT_EN
            dec_q     <= dec;
`endif
          end
        end
        LOAD: begin
          if (rk_valid) begin
            state      <= ROUND;
            round_idx  <= ONE_IDX;
            mux_sel    <= 1'b1;
            last_round <= (NR_IDX == ONE_IDX);
          end
        end
        ROUND: begin
          if (rk_valid) begin
            if (last_round) begin
              state      <= DONE;
              mux_sel    <= 1'b0;
              last_round <= 1'b0;
              busy       <= 1'b0;
              out_valid  <= 1'b1;
            end else begin
              round_idx  <= round_idx + ONE_IDX;
              last_round <= ((round_idx + ONE_IDX) == NR_IDX);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // Back-to-back accept skips the IDLE bubble.
            if (in_valid) begin
              state     <= LOAD;
              round_idx <= '0;
              busy      <= 1'b1;
`ifdef AES_DECRYPT_EN
              dec_q     <= dec;
`endif
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake and write strobe follow live inputs; busy marks LOAD/ROUND.
  assign in_ready = rst_n && ((state == IDLE) || ((state == DONE) && out_ready));
  assign state_we = rst_n && busy && rk_valid;

`ifdef AES_DECRYPT_EN
  assign key_idx = dec_q ? (NR_IDX - round_idx) : round_idx;
`else
  assign key_idx = round_idx;
`endif

endmodule
